// File: rtl/ysyx_23060201_lsu.sv
// rtl/ysyx_23060201_lsu.sv - load/store unit between EXU and the memory stage
//
// Purpose: takes one load/store op at a time from EXU, issues a single
// word-aligned write or read to the memory stage, extends load data and
// hands the result to WBU.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           EXU handshake
//   in_is_load, in_is_store     op kind (exclusive)
//   in_funct3, in_addr          RV32 width/sign code, byte address
//   in_wdata, in_rd             store source, destination register
//   mem_wen/waddr/wdata/wmask   memory write port (single-cycle strobe)
//   mem_ren/raddr               memory read request (single-cycle strobe)
//   mem_rvalid/mem_rdata        memory read return
//   out_valid/out_ready         WBU handshake
//   out_rdata, out_rd           extended load result, destination register
//   out_wen, out_err            write-back enable, misaligned/illegal flag

module ysyx_23060201_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [4:0]            in_rd,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic [4:0]            out_rd,
  output logic                  out_wen,
  output logic                  out_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, next_state;

  logic                  is_load_q;
  logic                  is_store_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [4:0]            rd_q;
  logic                  err_q;

  // Decode of the incoming op, evaluated only when it is captured in IDLE.
  logic illegal_f3;
  logic misaligned;
  logic in_err;

  always_comb begin
    illegal_f3 = 1'b0;
    if (in_is_load)
      illegal_f3 = (in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11);
    else if (in_is_store)
      illegal_f3 = (in_funct3 >= 3'b011);
    misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                 ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    // An op that is neither (or both) load and store is also rejected.
    in_err = (in_is_load == in_is_store) || illegal_f3 || misaligned;
  end

  // Byte offset within the word, as a bit shift amount.
  logic [4:0] lane_shift;
  assign lane_shift = {addr_q[1:0], 3'b000};

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  logic [DATA_WIDTH-1:0] rshifted;
  logic [DATA_WIDTH-1:0] load_ext;

  always_comb begin
    rshifted = mem_rdata >> lane_shift;
    case (funct3_q)
      3'b000:  load_ext = {{24{rshifted[7]}}, rshifted[7:0]};
      3'b001:  load_ext = {{16{rshifted[15]}}, rshifted[15:0]};
      3'b100:  load_ext = {24'h000000, rshifted[7:0]};
      3'b101:  load_ext = {16'h0000, rshifted[15:0]};
      default: load_ext = rshifted;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid)
          next_state = in_err ? RESP : ISSUE;
      end
      ISSUE: begin
        next_state = is_load_q ? WAIT_R : RESP;
      end
      WAIT_R: begin
        // rvalid seen during ISSUE never reaches here, so the earliest
        // honoured return is the cycle after the read strobe.
        if (mem_rvalid)
          next_state = RESP;
      end
      RESP: begin
        if (out_ready)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_q       <= 5'd0;
      err_q      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && in_valid) begin
        is_load_q  <= in_is_load;
        is_store_q <= in_is_store;
        funct3_q   <= in_funct3;
        addr_q     <= in_addr;
        wdata_q    <= in_wdata;
        rd_q       <= in_rd;
        err_q      <= in_err;
        rdata_q    <= '0;
      end
      if (state == WAIT_R && mem_rvalid)
        rdata_q <= load_ext;
    end
  end

  // Write port: strobe plus payload only during ISSUE of a store.
  logic [3:0] lane_mask;
  logic [3:0] lane_mask_shifted;

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
    lane_mask_shifted = lane_mask << addr_q[1:0];
  end

  assign mem_wen   = (state == ISSUE) && is_store_q;
  assign mem_waddr = mem_wen ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata = mem_wen ? (wdata_q << lane_shift) : '0;
  assign mem_wmask = mem_wen ? {4'b0000, lane_mask_shifted} : 8'h00;

  assign mem_ren   = (state == ISSUE) && is_load_q;
  assign mem_raddr = mem_ren ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;

  // Response side: everything held from registers while in RESP.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign out_rdata = out_valid ? rdata_q : '0;
  assign out_rd    = out_valid ? rd_q : 5'd0;
  assign out_wen   = out_valid && is_load_q && !err_q;
  assign out_err   = out_valid && err_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// tb/tb_ysyx_23060201_lsu.sv - directed self-checking bench for ysyx_23060201_lsu

module tb_ysyx_23060201_lsu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_load (in_is_load),
    .in_is_store(in_is_store),
    .in_funct3  (in_funct3),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .in_rd      (in_rd),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rdata  (out_rdata),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_is_load  = ld;
    in_is_store = st;
    in_funct3   = f3;
    in_addr     = addr;
    in_wdata    = wd;
    in_rd       = rd;
    tick();
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
  endtask

  // Load whose data returns 3 cycles after the read strobe; a junk rvalid is
  // offered in the strobe cycle itself and must be ignored.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata);
    send_op(1'b1, 1'b0, f3, addr, 32'h0, rd);
    check({tag, "_ren"}, {31'd0, mem_ren}, 32'd1);
    check({tag, "_raddr"}, mem_raddr, {addr[31:2], 2'b00});
    check({tag, "_wen"}, {31'd0, mem_wen}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    check({tag, "_early_rvalid_ignored"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ren_pulse"}, {31'd0, mem_ren}, 32'd0);
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    in_funct3   = 3'b000;
    in_addr     = 32'h0;
    in_wdata    = 32'h0;
    in_rd       = 5'd0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    out_ready   = 1'b1;
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
    rst_n = 1'b1;
    tick();

    // SW aligned
    send_op(1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'hDEAD_BEEF, 5'd3);
    check("sw_wen", {31'd0, mem_wen}, 32'd1);
    check("sw_waddr", mem_waddr, 32'h8000_0008);
    check("sw_wmask", {24'd0, mem_wmask}, 32'h0F);
    check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sw_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("sw_wen_pulse", {31'd0, mem_wen}, 32'd0);
    check("sw_waddr_idle", mem_waddr, 32'h0);
    check("sw_out_valid", {31'd0, out_valid}, 32'd1);
    check("sw_out_wen", {31'd0, out_wen}, 32'd0);
    check("sw_out_err", {31'd0, out_err}, 32'd0);
    check("sw_out_rdata", out_rdata, 32'h0);
    tick();
    check("sw_done_valid", {31'd0, out_valid}, 32'd0);
    check("sw_done_ready", {31'd0, in_ready}, 32'd1);

    // SB to the top lane
    send_op(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 5'd0);
    check("sb_wmask", {24'd0, mem_wmask}, 32'h08);
    check("sb_wdata", mem_wdata, 32'hA500_0000);
    check("sb_waddr", mem_waddr, 32'h8000_0000);
    tick();
    tick();

    // SH to the upper half
    send_op(1'b0, 1'b1, 3'b001, 32'h8000_0102, 32'h1234_BEEF, 5'd0);
    check("sh_wmask", {24'd0, mem_wmask}, 32'h0C);
    check("sh_wdata", mem_wdata, 32'hBEEF_0000);
    check("sh_waddr", mem_waddr, 32'h8000_0100);
    tick();
    tick();

    // LB sign-extended
    run_load("lb", 3'b000, 32'h8000_0002, 5'd5, 32'h12F0_3456);
    check("lb_out_valid", {31'd0, out_valid}, 32'd1);
    check("lb_out_rdata", out_rdata, 32'hFFFF_FFF0);
    check("lb_out_wen", {31'd0, out_wen}, 32'd1);
    check("lb_out_rd", {27'd0, out_rd}, 32'd5);
    check("lb_out_err", {31'd0, out_err}, 32'd0);
    tick();
    check("lb_done", {31'd0, in_ready}, 32'd1);

    // LBU with WBU back-pressure for 5 cycles
    out_ready = 1'b0;
    run_load("lbu", 3'b100, 32'h8000_0002, 5'd6, 32'h12F0_3456);
    for (int i = 0; i < 5; i++) begin
      check("lbu_hold_valid", {31'd0, out_valid}, 32'd1);
      check("lbu_hold_rdata", out_rdata, 32'h0000_00F0);
      check("lbu_hold_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    check("lbu_hold_valid_last", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("lbu_done_valid", {31'd0, out_valid}, 32'd0);
    check("lbu_done_ready", {31'd0, in_ready}, 32'd1);

    // LH misaligned: straight to RESP with error, no memory strobes
    send_op(1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'h0, 5'd7);
    check("lh_mis_ren", {31'd0, mem_ren}, 32'd0);
    check("lh_mis_wen", {31'd0, mem_wen}, 32'd0);
    check("lh_mis_valid", {31'd0, out_valid}, 32'd1);
    check("lh_mis_err", {31'd0, out_err}, 32'd1);
    check("lh_mis_rdata", out_rdata, 32'h0);
    check("lh_mis_wen_out", {31'd0, out_wen}, 32'd0);
    tick();

    // Store with illegal funct3
    send_op(1'b0, 1'b1, 3'b011, 32'h8000_0000, 32'h1, 5'd0);
    check("st_ill_wen", {31'd0, mem_wen}, 32'd0);
    check("st_ill_err", {31'd0, out_err}, 32'd1);
    tick();

    // Reset while waiting for read data
    send_op(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd9);
    tick();
    check("rst_mid_pre_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_ren", {31'd0, mem_ren}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    tick();
    tick();
    mem_rvalid = 1'b0;
    check("rst_mid_late_rvalid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_idle", {31'd0, in_ready}, 32'd1);
    check("rst_mid_no_ren", {31'd0, mem_ren}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
